// File: rtl/audio_mix_pkg.sv
// Shared types and sizing helpers for the N-channel audio mixer.
// Offset-binary helpers are reused by the output stages.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SCALE,
    SAT
  } mix_state_t;

  function automatic int acc_w(
    input int in_w,
    input int gain_w,
    input int nch
  );
    return in_w + gain_w + $clog2(nch) + 1;
  endfunction

  function automatic longint unsigned mid(
    input int w
  );
    return 64'd1 << (w - 1);
  endfunction

  function automatic longint unsigned UNITY_GAIN(
    input int gain_w
  );
    return 64'd1 << (gain_w - 1);
  endfunction

endpackage

// File: rtl/audio_mixer_n_sat.sv
// Signed clamp from a wide value to OW bits, emitted offset-binary.
// Purely combinational so later output stages can reuse it.
module audio_sat #(
  parameter int IW = 32,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] i_v,
  output logic        [OW-1:0] o_v
);

  localparam int HW = IW - OW + 1;

  logic [HW-1:0] w_hi;
  logic          w_fit;
  logic [OW-1:0] w_c;

  assign w_hi  = i_v[IW-1 -: HW];
  // Fits when every bit above the target sign bit matches it.
  assign w_fit = (&w_hi) | ~(|w_hi);

  always_comb begin
    w_c = i_v[OW-1:0];
    if (!w_fit) begin
      if (i_v[IW-1]) w_c = {1'b1, {(OW-1){1'b0}}};
      else           w_c = {1'b0, {(OW-1){1'b1}}};
    end
  end

  assign o_v = {~w_c[OW-1], w_c[OW-2:0]};

endmodule

// File: rtl/audio_mixer_n.sv
// Time-multiplexed N-channel mixer: one MAC per clock, master
// volume ramp, saturation to OUT_W, offset-binary output.
module audio_mixer_n
  import audio_mix_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int GAIN_W    = 8,
  parameter int MV_W      = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic                   sound_enable,
  input  logic [NCH*IN_W-1:0]    ch_in,
  input  logic [NCH*GAIN_W-1:0]  ch_gain,
  output logic [OUT_W-1:0]       out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int ACC_W  = acc_w(IN_W, GAIN_W, NCH);
  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam int VOL_W  = MV_W + 1;
  localparam int T_W    = ACC_W + VOL_W + 1;
  localparam int SHL    = (OUT_W > IN_W) ? OUT_W - IN_W : 0;
  localparam int SHR    = (IN_W > OUT_W) ? IN_W - OUT_W : 0;
  localparam int ALN_W  = T_W + SHL;
  localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);
  localparam logic [VOL_W-1:0] VMAX = {1'b1, {MV_W{1'b0}}};
  localparam logic [OUT_W-1:0] MIDO = OUT_W'(mid(OUT_W));
  localparam logic [VOL_W:0]   STEP = (VOL_W+1)'(RAMP_STEP);

  mix_state_t r_state;
  mix_state_t w_nstate;

  logic [IN_W-1:0]   r_ch   [NCH];
  logic [GAIN_W-1:0] r_gain [NCH];

  logic [IDX_W-1:0]        r_idx;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [T_W-1:0]   r_t;
  logic [VOL_W-1:0]        r_vol;
  logic [OUT_W-1:0]        r_out;
  logic                    r_valid;
  logic                    r_overrun;

  logic w_busy;
  logic w_start;
  logic w_mac;
  logic w_scale;
  logic w_done;

  logic [IN_W-1:0]          w_csel;
  logic signed [IN_W-1:0]   w_sch;
  logic signed [GAIN_W:0]   w_gs;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_x;

  logic signed [ACC_W-1:0] w_accs;
  logic signed [VOL_W:0]   w_volx;
  logic signed [T_W-1:0]   w_mul;
  logic signed [T_W-1:0]   w_t;
  logic signed [ALN_W-1:0] w_aln;
  logic [OUT_W-1:0]        w_sat;

  logic [VOL_W:0]   w_vup;
  logic [VOL_W-1:0] w_vnext;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  // Next-state logic
  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_nstate = MAC;
      MAC:     if (r_idx == LAST) w_nstate = SCALE;
      SCALE:   w_nstate = SAT;
      SAT:     w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // Output / control decode; the out_valid cycle still counts as busy
  always_comb begin
    w_busy  = (r_state != IDLE) | r_valid;
    w_start = sample_en & ~w_busy;
    w_mac   = (r_state == MAC);
    w_scale = (r_state == SCALE);
    w_done  = (r_state == SAT);
  end

  assign w_csel   = r_ch[r_idx];
  assign w_sch    = signed'({~w_csel[IN_W-1], w_csel[IN_W-2:0]});
  assign w_gs     = signed'({1'b0, r_gain[r_idx]});
  assign w_prod   = PROD_W'(w_sch) * PROD_W'(w_gs);
  assign w_prod_x = ACC_W'(w_prod);

  assign w_accs = r_acc >>> (GAIN_W - 1);
  assign w_volx = signed'({1'b0, r_vol});
  assign w_mul  = T_W'(w_accs) * T_W'(w_volx);
  assign w_t    = w_mul >>> MV_W;

  assign w_aln = (ALN_W'(r_t) <<< SHL) >>> SHR;

  audio_sat #(
    .IW (ALN_W),
    .OW (OUT_W)
  ) u_sat (
    .i_v (w_aln),
    .o_v (w_sat)
  );

  assign w_vup = {1'b0, r_vol} + STEP;

  always_comb begin
    w_vnext = r_vol;
    if (sound_enable) begin
      if (w_vup > {1'b0, VMAX}) w_vnext = VMAX;
      else                      w_vnext = w_vup[VOL_W-1:0];
    end else begin
      if ({1'b0, r_vol} > STEP) w_vnext = r_vol - STEP[VOL_W-1:0];
      else                      w_vnext = '0;
    end
  end

  // Snapshot only changes on an accepted strobe
  always_ff @(posedge clk) begin
    if (w_start) begin
      for (int k = 0; k < NCH; k++) begin
        r_ch[k]   <= ch_in[k*IN_W +: IN_W];
        r_gain[k] <= ch_gain[k*GAIN_W +: GAIN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_acc     <= '0;
      r_t       <= '0;
      r_vol     <= '0;
      r_out     <= MIDO;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (sample_en && w_busy) r_overrun <= 1'b1;
      if (w_start) begin
        r_acc <= '0;
        r_idx <= '0;
      end
      if (w_mac) begin
        r_acc <= r_acc + w_prod_x;
        if (r_idx != LAST) r_idx <= r_idx + 1'b1;
      end
      if (w_scale) r_t <= w_t;
      if (w_done) begin
        r_out <= w_sat;
        r_vol <= w_vnext;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign busy      = w_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_audio_mixer_n.sv
// Self-checking bench for audio_mixer_n: vector table, random mixes
// against an arithmetic model, and hand-built multi-cycle cases.
module tb_audio_mixer_n;

  typedef logic [3:0][15:0] ch4_t;
  typedef logic [3:0][7:0]  g4_t;

  typedef struct {
    ch4_t        ch;
    g4_t         g;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic        sound_enable;
  ch4_t        ch_in;
  g4_t         ch_gain;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  logic        rst_r;
  logic        se_r;
  logic        en_r;
  ch4_t        ch_r;
  g4_t         g_r;
  logic [15:0] out_r;
  logic        ov_r;
  logic        busy_r;
  logic        orun_r;

  int nvec = 0;
  int nerr = 0;
  int mvol;
  int mvol_r;

  always #5 clk = ~clk;

  audio_mixer_n #(
    .NCH(4), .IN_W(16), .OUT_W(16),
    .GAIN_W(8), .MV_W(8), .RAMP_STEP(256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .sound_enable (sound_enable),
    .ch_in        (ch_in),
    .ch_gain      (ch_gain),
    .out          (out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  audio_mixer_n #(
    .NCH(4), .IN_W(16), .OUT_W(16),
    .GAIN_W(8), .MV_W(8), .RAMP_STEP(1)
  ) dut_r (
    .clk          (clk),
    .rst          (rst_r),
    .sample_en    (se_r),
    .sound_enable (en_r),
    .ch_in        (ch_r),
    .ch_gain      (g_r),
    .out          (out_r),
    .out_valid    (ov_r),
    .busy         (busy_r),
    .overrun      (orun_r)
  );

  function automatic logic [15:0] ref_out(
    input ch4_t c,
    input g4_t  g,
    input int   vol
  );
    longint s;
    longint t;
    s = 0;
    for (int k = 0; k < 4; k++)
      s += (longint'(c[k]) - 32768) * longint'(g[k]);
    s = s >>> 7;
    t = (s * vol) >>> 8;
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return 16'(t + 32768);
  endfunction

  function automatic int vstep(
    input int v, input int st, input logic en
  );
    if (en) return (v + st > 256) ? 256 : v + st;
    return (v - st < 0) ? 0 : v - st;
  endfunction

  task automatic chk(
    input string nm, input longint act, input longint exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_mix(
    input  ch4_t        c,
    input  g4_t         g,
    output logic [15:0] o,
    output int          lat,
    output logic        b1
  );
    @(negedge clk);
    ch_in     = c;
    ch_gain   = g;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    b1        = busy;
    ch_in     = {$urandom, $urandom};
    ch_gain   = $urandom;
    lat       = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    o = out;
  endtask

  task automatic ramp_mix(output logic [15:0] o);
    int n;
    @(negedge clk);
    se_r = 1'b1;
    @(negedge clk);
    se_r = 1'b0;
    n = 1;
    while (!ov_r && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ramp_lat", n, 7);
    o = out_r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [15:0] o;
    logic [15:0] prev;
    int          lat;
    int          nv;
    logic        b1;

    rst = 1'b1; sample_en = 1'b0; sound_enable = 1'b1;
    ch_in = '0; ch_gain = '0;
    rst_r = 1'b1; se_r = 1'b0; en_r = 1'b1;
    ch_r = {16'h8000, 16'h8000, 16'h8000, 16'hFFFF};
    g_r  = {8'd0, 8'd0, 8'd0, 8'd128};
    repeat (3) @(negedge clk);
    rst = 1'b0; rst_r = 1'b0;
    mvol = 0; mvol_r = 0;
    repeat (4) @(negedge clk);

    chk("rst_out", out, 16'h8000);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    run_mix({48'h0, 16'hC000}, {24'h0, 8'd128}, o, lat, b1);
    chk("vol0_out", o, 16'h8000);
    chk("vol0_busy", b1, 1);
    mvol = vstep(mvol, 256, 1'b1);
    run_mix({48'h0, 16'hC000}, {24'h0, 8'd128}, o, lat, b1);
    chk("unity_out", o, 16'hC000);
    chk("unity_lat", lat, 7);
    mvol = vstep(mvol, 256, 1'b1);
    @(negedge clk);
    chk("idle_busy", busy, 0);

    tbl.push_back('{{4{16'hFFFF}}, {4{8'd255}}, 16'hFFFF});
    tbl.push_back('{{4{16'h0000}}, {4{8'd255}}, 16'h0000});
    tbl.push_back('{{32'h0, 16'h6000, 16'hA000},
                    {16'h0, 8'd128, 8'd128}, 16'h8000});
    tbl.push_back('{{16'h1234, 16'hFFFF, 16'h0, 16'h4321},
                    {4{8'd0}}, 16'h8000});
    tbl.push_back('{{48'h0, 16'h4000}, {24'h0, 8'd128}, 16'h4000});
    tbl.push_back('{{16'h8000, 16'h8000, 16'hA000, 16'h8000},
                    {8'd0, 8'd0, 8'd255, 8'd0}, 16'hBFC0});
    for (int i = 0; i < 24; i++) begin
      v.ch  = {$urandom, $urandom};
      v.g   = $urandom;
      v.exp = ref_out(v.ch, v.g, 256);
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      run_mix(tbl[i].ch, tbl[i].g, o, lat, b1);
      chk($sformatf("vec%0d_out", i), o, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, 7);
    end

    // second strobe two clocks into a mix
    @(negedge clk);
    ch_in = {48'h0, 16'h9000}; ch_gain = {24'h0, 8'd128};
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    sample_en = 1'b1;
    ch_in = {4{16'h7000}}; ch_gain = {4{8'd255}};
    @(negedge clk);
    sample_en = 1'b0;
    nv = 0;
    o  = 16'h0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) begin
        nv++;
        o = out;
      end
      @(negedge clk);
    end
    chk("ovr_nvalid", nv, 1);
    chk("ovr_out", o, 16'h9000);
    chk("ovr_flag", overrun, 1);

    // strobe landing on the out_valid clock is dropped
    run_mix({48'h0, 16'hC000}, {24'h0, 8'd128}, o, lat, b1);
    chk("ov_clk_out", o, 16'hC000);
    chk("ov_clk_busy", busy, 1);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) nv++;
      @(negedge clk);
    end
    chk("ov_clk_nvalid", nv, 0);
    chk("ov_sticky", overrun, 1);

    // reset in the middle of MAC
    @(negedge clk);
    ch_in = {48'h0, 16'hC000}; ch_gain = {24'h0, 8'd128};
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mvol = 0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) nv++;
      @(negedge clk);
    end
    chk("rstmid_nvalid", nv, 0);
    chk("rstmid_out", out, 16'h8000);
    chk("rstmid_ovr", overrun, 0);
    chk("rstmid_busy", busy, 0);
    run_mix({48'h0, 16'hC000}, {24'h0, 8'd128}, o, lat, b1);
    chk("post_rst_out", o, ref_out({48'h0, 16'hC000},
                                   {24'h0, 8'd128}, mvol));
    mvol = vstep(mvol, 256, 1'b1);

    // slow ramp up then down on the step-1 instance
    en_r = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ramp_mix(o);
      chk("ramp_up", o, ref_out(ch_r, g_r, mvol_r));
      mvol_r = vstep(mvol_r, 1, 1'b1);
    end
    en_r = 1'b0;
    ramp_mix(o);
    chk("ramp_top", o, 16'hFFFF);
    mvol_r = vstep(mvol_r, 1, 1'b0);
    prev = o;
    for (int i = 0; i < 256; i++) begin
      ramp_mix(o);
      chk("ramp_dn", o, ref_out(ch_r, g_r, mvol_r));
      chk("ramp_step", ((prev - o) >= 127) && ((prev - o) <= 128), 1);
      mvol_r = vstep(mvol_r, 1, 1'b0);
      prev = o;
    end
    chk("ramp_floor", o, 16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
